// File: rtl/ysyx_25040101_ifu_pkg.sv
// Shared types and constants for the ysyx_25040101 instruction fetch unit.
// FSM encoding, AXI response code and the default boot address live here.
package ysyx_25040101_pkg;

   typedef enum logic [1:0] {
      IFU_REQ   = 2'd0,
      IFU_WAIT  = 2'd1,
      IFU_VALID = 2'd2,
      IFU_HALT  = 2'd3
   } ifu_state_t;

   localparam logic [1:0]  RRESP_OKAY       = 2'b00;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

   // Only the two low bits decide alignment of a 32-bit instruction address.
   function automatic logic is_word_aligned(input logic [1:0] addr_lo);
      return addr_lo == 2'b00;
   endfunction

endpackage

// File: rtl/ysyx_25040101_ifu_perf.sv
// Fetch / stall performance counters for the IFU; both wrap modulo 2^32.
// Only built when YSYX_25040101_IFU_PERF_EN is defined, matching its single instantiation site.
`ifdef YSYX_25040101_IFU_PERF_EN
module ysyx_25040101_ifu_perf (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_fetch_ok,
   input  logic        i_stall,
   output logic [31:0] o_fetch_cnt,
   output logic [31:0] o_stall_cnt
);

   logic [31:0] r_fetch_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_cnt <= 32'h0;
         r_stall_cnt <= 32'h0;
      end else begin
         if (i_fetch_ok) r_fetch_cnt <= r_fetch_cnt + 32'h1;
         if (i_stall)    r_stall_cnt <= r_stall_cnt + 32'h1;
      end
   end

   assign o_fetch_cnt = r_fetch_cnt;
   assign o_stall_cnt = r_stall_cnt;

endmodule
`endif

// File: rtl/ysyx_25040101_ifu.sv
// Handshaked instruction fetch unit: one outstanding AR/R read, one instruction presented at a time.
// Optional counters enabled by YSYX_25040101_IFU_PERF_EN; otherwise fetch_cnt_o/stall_cnt_o read as zero.
module ysyx_25040101_ifu
   import ysyx_25040101_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic              clk,
   input  logic              rst,
   output logic              arvalid_o,
   output logic [ADDR_W-1:0] araddr_o,
   input  logic              arready_i,
   input  logic              rvalid_i,
   input  logic [ADDR_W-1:0] rdata_i,
   input  logic [1:0]        rresp_i,
   output logic              rready_o,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic [ADDR_W-1:0] inst_o,
   output logic [ADDR_W-1:0] pc_o,
   input  logic [ADDR_W-1:0] next_pc_i,
   output logic              fetch_err_o,
   output logic [31:0]       fetch_cnt_o,
   output logic [31:0]       stall_cnt_o
);

   ifu_state_t        r_state;
   ifu_state_t        w_state_next;
   logic [ADDR_W-1:0] r_araddr;
   logic [ADDR_W-1:0] w_araddr_next;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_next;
   logic [ADDR_W-1:0] r_inst;
   logic [ADDR_W-1:0] w_inst_next;
   logic              r_err;
   logic              w_err_next;

   logic w_r_beat;
   logic w_r_ok;
   logic w_npc_ok;

   assign w_r_beat = (r_state == IFU_WAIT) && rvalid_i;
   assign w_r_ok   = w_r_beat && (rresp_i == RRESP_OKAY);
   assign w_npc_ok = is_word_aligned(next_pc_i[1:0]);

   always_comb begin
      w_state_next  = r_state;
      w_araddr_next = r_araddr;
      w_pc_next     = r_pc;
      w_inst_next   = r_inst;
      w_err_next    = r_err;
      unique case (r_state)
         IFU_REQ: begin
            if (arready_i) w_state_next = IFU_WAIT;
         end
         IFU_WAIT: begin
            if (rvalid_i) begin
               if (rresp_i == RRESP_OKAY) begin
                  w_inst_next  = rdata_i;
                  w_pc_next    = r_araddr;
                  w_state_next = IFU_VALID;
               end else begin
                  w_err_next   = 1'b1;
                  w_state_next = IFU_HALT;
               end
            end
         end
         IFU_VALID: begin
            // The core owns PC arithmetic; a misaligned target is a fatal fetch fault.
            if (inst_ready_i) begin
               if (w_npc_ok) begin
                  w_araddr_next = next_pc_i;
                  w_state_next  = IFU_REQ;
               end else begin
                  w_err_next   = 1'b1;
                  w_state_next = IFU_HALT;
               end
            end
         end
         default: begin
            w_state_next = IFU_HALT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IFU_REQ;
         r_araddr <= RESET_PC;
         r_pc     <= RESET_PC;
         r_inst   <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_araddr <= w_araddr_next;
         r_pc     <= w_pc_next;
         r_inst   <= w_inst_next;
         r_err    <= w_err_next;
      end
   end

   // Handshake outputs decode straight from state, so inst_valid_o never depends on inst_ready_i.
   assign arvalid_o    = (r_state == IFU_REQ);
   assign rready_o     = (r_state == IFU_WAIT);
   assign inst_valid_o = (r_state == IFU_VALID);
   assign araddr_o     = r_araddr;
   assign pc_o         = r_pc;
   assign inst_o       = r_inst;
   assign fetch_err_o  = r_err;

`ifdef YSYX_25040101_IFU_PERF_EN
   logic w_stall;
   assign w_stall = (r_state == IFU_REQ) || (r_state == IFU_WAIT);

   ysyx_25040101_ifu_perf u_perf (
      .clk         (clk),
      .rst         (rst),
      .i_fetch_ok  (w_r_ok),
      .i_stall     (w_stall),
      .o_fetch_cnt (fetch_cnt_o),
      .o_stall_cnt (stall_cnt_o)
   );
`else
   assign fetch_cnt_o = 32'h0;
   assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_ysyx_25040101_ifu.sv
// Scoreboard bench for ysyx_25040101_ifu: directed tests push expected AR addresses and
// instructions; a monitor pops and compares on every handshake. Memory and core are modelled.
module tb_ysyx_25040101_ifu;

`ifdef YSYX_25040101_IFU_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk;
   logic        rst;
   logic        arvalid_o;
   logic [31:0] araddr_o;
   logic        arready_i;
   logic        rvalid_i;
   logic [31:0] rdata_i;
   logic [1:0]  rresp_i;
   logic        rready_o;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic [31:0] next_pc_i;
   logic        fetch_err_o;
   logic [31:0] fetch_cnt_o;
   logic [31:0] stall_cnt_o;

   ysyx_25040101_ifu dut (
      .clk          (clk),
      .rst          (rst),
      .arvalid_o    (arvalid_o),
      .araddr_o     (araddr_o),
      .arready_i    (arready_i),
      .rvalid_i     (rvalid_i),
      .rdata_i      (rdata_i),
      .rresp_i      (rresp_i),
      .rready_o     (rready_o),
      .inst_valid_o (inst_valid_o),
      .inst_ready_i (inst_ready_i),
      .inst_o       (inst_o),
      .pc_o         (pc_o),
      .next_pc_i    (next_pc_i),
      .fetch_err_o  (fetch_err_o),
      .fetch_cnt_o  (fetch_cnt_o),
      .stall_cnt_o  (stall_cnt_o)
   );

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_ar[$];
   logic [31:0] exp_inst[$];
   logic [31:0] exp_pc[$];
   logic [31:0] npc_q[$];

   int ar_lat = 0;
   int r_lat  = 0;
   int rd_lat = 0;
   bit bad_resp = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [31:0] rom(input logic [31:0] addr);
      case (addr)
         32'h8000_0000: rom = 32'h0000_0413;
         32'h8000_0004: rom = 32'h0010_0093;
         32'h8000_0010: rom = 32'h0020_8133;
         32'hFFFF_FFFC: rom = 32'h0000_006F;
         32'h0000_0000: rom = 32'h0000_0013;
         default:       rom = 32'h0BAD_0013;
      endcase
   endfunction

   // Memory + core model: decisions made at negedge apply at the next rising edge.
   initial begin
      logic [31:0] mem_addr;
      int ar_cnt, r_cnt, rd_cnt;
      mem_addr = 32'h0;
      ar_cnt = 0; r_cnt = 0; rd_cnt = 0;
      arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'h0; rresp_i = 2'b00;
      inst_ready_i = 1'b0; next_pc_i = 32'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            arready_i = 1'b0; rvalid_i = 1'b0; inst_ready_i = 1'b0;
            ar_cnt = 0; r_cnt = 0; rd_cnt = 0;
            continue;
         end
         arready_i = 1'b0;
         if (arvalid_o) begin
            if (ar_cnt >= ar_lat) begin
               arready_i = 1'b1;
               mem_addr  = araddr_o;
               ar_cnt    = 0;
            end else ar_cnt++;
         end
         if (rready_o) begin
            if (r_cnt >= r_lat) begin
               rvalid_i = 1'b1;
               rdata_i  = rom(mem_addr);
               rresp_i  = bad_resp ? 2'b10 : 2'b00;
               bad_resp = 1'b0;
               r_cnt    = 0;
            end else begin
               rvalid_i = 1'b0;
               rdata_i  = 32'hDEAD_BEEF;
               r_cnt++;
            end
         end else begin
            // Junk beat outside WAIT must be ignored, including its error response.
            rvalid_i = 1'b1;
            rdata_i  = 32'hDEAD_BEEF;
            rresp_i  = 2'b11;
         end
         inst_ready_i = 1'b0;
         next_pc_i    = 32'h8000_0022;
         if (inst_valid_o && npc_q.size() > 0) begin
            if (rd_cnt >= rd_lat) begin
               inst_ready_i = 1'b1;
               next_pc_i    = npc_q.pop_front();
               rd_cnt       = 0;
            end else rd_cnt++;
         end
      end
   end

   // Monitor: pops expectations on each handshake and checks hold/one-outstanding rules.
   initial begin
      bit          p_arhold, p_ihold;
      logic [31:0] p_araddr, p_inst, p_pc;
      p_arhold = 1'b0; p_ihold = 1'b0;
      p_araddr = 32'h0; p_inst = 32'h0; p_pc = 32'h0;
      forever begin
         step();
         if (rst) begin
            p_arhold = 1'b0; p_ihold = 1'b0;
            continue;
         end
         if (p_arhold && arvalid_o) chk("ar_stable", araddr_o, p_araddr);
         if (p_ihold) begin
            chk("valid_held", {31'h0, inst_valid_o}, 32'h1);
            chk("inst_stable", inst_o, p_inst);
            chk("pc_stable", pc_o, p_pc);
         end
         chk("one_outstanding", {31'h0, arvalid_o & (rready_o | inst_valid_o)}, 32'h0);
         if (arvalid_o && arready_i) begin
            $display("AR   addr=%h", araddr_o);
            if (exp_ar.size() == 0) begin
               checks++; errors++;
               $display("FAIL ar_unexpected: got addr %h expected no request", araddr_o);
            end else chk("ar_addr", araddr_o, exp_ar.pop_front());
         end
         if (inst_valid_o && inst_ready_i) begin
            $display("INST pc=%h inst=%h next_pc=%h", pc_o, inst_o, next_pc_i);
            if (exp_inst.size() == 0) begin
               checks++; errors++;
               $display("FAIL inst_unexpected: got pc %h expected no instruction", pc_o);
            end else begin
               chk("inst_data", inst_o, exp_inst.pop_front());
               chk("inst_pc", pc_o, exp_pc.pop_front());
            end
         end
         p_arhold = arvalid_o && !arready_i;
         p_araddr = araddr_o;
         p_ihold  = inst_valid_o && !inst_ready_i;
         p_inst   = inst_o;
         p_pc     = pc_o;
      end
   end

   // Asserts rst mid-cycle, checks the asynchronous reset values, releases; returns in cycle 0.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_araddr", araddr_o, RST_PC);
      chk("rst_pc", pc_o, RST_PC);
      chk("rst_inst", inst_o, 32'h0);
      chk("rst_inst_valid", {31'h0, inst_valid_o}, 32'h0);
      chk("rst_rready", {31'h0, rready_o}, 32'h0);
      chk("rst_err", {31'h0, fetch_err_o}, 32'h0);
      chk("rst_fetch_cnt", fetch_cnt_o, 32'h0);
      chk("rst_stall_cnt", stall_cnt_o, 32'h0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      step();
   endtask

   task automatic wait_drain(input string name, input int budget);
      for (int i = 0; i < budget && (exp_ar.size() != 0 || exp_inst.size() != 0); i++) step();
      chk(name, 32'(exp_ar.size() + exp_inst.size()), 32'h0);
   endtask

   task automatic wait_beat(input string name, input int budget);
      for (int i = 0; i < budget && !(rvalid_i && rready_o); i++) step();
      chk(name, {31'h0, rvalid_i && rready_o}, 32'h1);
   endtask

   task automatic wait_valid(input string name, input int budget);
      for (int i = 0; i < budget && !inst_valid_o; i++) step();
      chk(name, {31'h0, inst_valid_o}, 32'h1);
   endtask

   initial begin
      logic idle_bad;
      rst = 1'b1;

      // T1: zero-wait memory, cycle-exact first fetch.
      exp_ar.push_back(32'h8000_0000);
      exp_ar.push_back(32'h8000_0004);
      exp_inst.push_back(32'h0000_0413); exp_pc.push_back(32'h8000_0000);
      npc_q.push_back(32'h8000_0004);
      do_reset();
      chk("t1_c0_arvalid", {31'h0, arvalid_o}, 32'h1);
      chk("t1_c0_araddr", araddr_o, 32'h8000_0000);
      step();
      chk("t1_c1_rready", {31'h0, rready_o}, 32'h1);
      step();
      chk("t1_c2_valid", {31'h0, inst_valid_o}, 32'h1);
      chk("t1_c2_inst", inst_o, 32'h0000_0413);
      step();
      chk("t1_c3_arvalid", {31'h0, arvalid_o}, 32'h1);
      chk("t1_c3_araddr", araddr_o, 32'h8000_0004);
      wait_drain("t1_drain", 20);

      // T2: 4 AR wait states then 3 R wait states.
      ar_lat = 4; r_lat = 3;
      exp_ar.push_back(32'h8000_0000);
      do_reset();
      wait_beat("t2_beat", 30);
      chk("t2_valid_before", {31'h0, inst_valid_o}, 32'h0);
      step();
      chk("t2_valid_after", {31'h0, inst_valid_o}, 32'h1);
      chk("t2_stall_cnt", stall_cnt_o, PERF ? 32'd9 : 32'd0);
      chk("t2_fetch_cnt", fetch_cnt_o, PERF ? 32'd1 : 32'd0);

      // T3: core stalls 5 cycles; the junk next_pc offered meanwhile must be ignored.
      ar_lat = 0; r_lat = 0; rd_lat = 5;
      exp_inst.push_back(32'h0000_0413); exp_pc.push_back(32'h8000_0000);
      exp_ar.push_back(32'h8000_0010);
      npc_q.push_back(32'h8000_0010);
      wait_drain("t3_drain", 30);
      chk("t3_no_err", {31'h0, fetch_err_o}, 32'h0);

      // T4: jump to the top word of the address space and wrap to zero.
      rd_lat = 0;
      exp_inst.push_back(32'h0020_8133); exp_pc.push_back(32'h8000_0010);
      exp_ar.push_back(32'hFFFF_FFFC);   npc_q.push_back(32'hFFFF_FFFC);
      exp_inst.push_back(32'h0000_006F); exp_pc.push_back(32'hFFFF_FFFC);
      exp_ar.push_back(32'h0000_0000);   npc_q.push_back(32'h0000_0000);
      wait_drain("t4_drain", 30);
      wait_valid("t4_valid", 10);
      chk("t4_inst", inst_o, 32'h0000_0013);

      // T5: misaligned next_pc halts with no further request.
      exp_inst.push_back(32'h0000_0013); exp_pc.push_back(32'h0000_0000);
      npc_q.push_back(32'h8000_0006);
      wait_drain("t5_drain", 10);
      step();
      chk("t5_err", {31'h0, fetch_err_o}, 32'h1);
      chk("t5_valid", {31'h0, inst_valid_o}, 32'h0);
      idle_bad = 1'b0;
      repeat (20) begin
         step();
         idle_bad = idle_bad | arvalid_o | inst_valid_o | rready_o | ~fetch_err_o;
      end
      chk("t5_halt_idle", {31'h0, idle_bad}, 32'h0);

      // T6: error response on the first beat, then recovery by reset.
      bad_resp = 1'b1;
      exp_ar.push_back(32'h8000_0000);
      do_reset();
      wait_beat("t6_beat", 10);
      step();
      chk("t6_err", {31'h0, fetch_err_o}, 32'h1);
      chk("t6_valid", {31'h0, inst_valid_o}, 32'h0);
      idle_bad = 1'b0;
      repeat (20) begin
         step();
         idle_bad = idle_bad | arvalid_o | inst_valid_o | rready_o | ~fetch_err_o;
      end
      chk("t6_halt_idle", {31'h0, idle_bad}, 32'h0);
      exp_ar.push_back(32'h8000_0000);
      do_reset();
      wait_valid("t6_refetch", 10);
      chk("t6_refetch_inst", inst_o, 32'h0000_0413);
      chk("t6_refetch_pc", pc_o, 32'h8000_0000);

      // T7: reset lands while a slow R beat is pending.
      r_lat = 10;
      exp_inst.push_back(32'h0000_0413); exp_pc.push_back(32'h8000_0000);
      exp_ar.push_back(32'h8000_0008);
      npc_q.push_back(32'h8000_0008);
      for (int i = 0; i < 20 && !rready_o; i++) step();
      chk("t7_in_wait", {31'h0, rready_o}, 32'h1);
      r_lat = 0;
      exp_ar.push_back(32'h8000_0000);
      do_reset();
      chk("t7_c0_araddr", araddr_o, 32'h8000_0000);
      chk("t7_c0_fetch_cnt", fetch_cnt_o, 32'h0);
      wait_valid("t7_valid", 10);
      chk("t7_inst", inst_o, 32'h0000_0413);
      chk("t7_fetch_cnt", fetch_cnt_o, PERF ? 32'd1 : 32'd0);

      wait_drain("final_drain", 10);
      chk("final_npc_left", 32'(npc_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_25040101_ifu.md
Name: ysyx_25040101_ifu

Overview:
Instruction fetch unit directly upstream of the single-cycle core datapath. It replaces the combinational pc-to-ROM path with a handshaked fetch over an AXI4-Lite-style read channel (AR/R). It presents one instruction at a time to the core with a valid/ready handshake. The core returns its computed next PC in the accept cycle.

Parameters:
RESET_PC, 32'h8000_0000, fetch address after reset
ADDR_W, 32, address and instruction width; only 32 is supported

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous active-high reset
arvalid_o  out  1  read-address valid to instruction memory
araddr_o  out  32  fetch address
arready_i  in  1  memory accepts address
rvalid_i  in  1  read-data valid
rdata_i  in  32  instruction word
rresp_i  in  2  response; 2'b00 = OKAY, anything else = error
rready_o  out  1  IFU can accept read data
inst_valid_o  out  1  inst_o/pc_o hold a fetched instruction
inst_ready_i  in  1  core consumes the instruction this cycle
inst_o  out  32  fetched instruction
pc_o  out  32  address of inst_o
next_pc_i  in  32  next PC from the core; sampled on handshake
fetch_err_o  out  1  sticky fault flag; fetching halts once set
fetch_cnt_o  out  32  completed fetches (optional feature)
stall_cnt_o  out  32  cycles spent in REQ/WAIT (optional feature)

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high. All state resets immediately on rst assertion.
- Reset values: state=REQ, araddr_o=RESET_PC, pc_o=RESET_PC, inst_o=0, inst_valid_o=0, rready_o=0, fetch_err_o=0, counters=0. arvalid_o is high in REQ, so it is 1 on the first cycle after rst deasserts. No stall cycle is inserted.
- FSM states: REQ, WAIT, VALID, HALT.
- REQ:
  - arvalid_o=1; araddr_o is held stable until arready_i.
  - arvalid_o & arready_i -> WAIT.
- WAIT:
  - rready_o=1.
  - On rvalid_i with rresp_i==0: latch inst_o=rdata_i, pc_o=araddr_o -> VALID.
  - On rvalid_i with rresp_i!=0: fetch_err_o=1 -> HALT.
  - rvalid_i is ignored outside WAIT.
- VALID:
  - inst_valid_o=1; inst_o and pc_o are held stable until inst_ready_i.
  - On inst_valid_o & inst_ready_i:
    - If next_pc_i[1:0]==0: araddr_o=next_pc_i -> REQ.
    - Otherwise: fetch_err_o=1, inst_valid_o=0 -> HALT.
- HALT: all handshake outputs are 0. Only rst leaves HALT.
- Latency: with zero-wait memory (arready_i and rvalid_i high), REQ->WAIT->VALID gives one instruction every 3 cycles. With wait states, each stalled cycle adds 1.
- Exactly one request is outstanding; the IFU never issues a second AR before the R beat completes.
- inst_valid_o is never combinationally dependent on inst_ready_i.
- Wrap-around: next_pc_i=32'hFFFF_FFFC is legal. Address arithmetic belongs to the core; the IFU does not increment.
- Counters wrap modulo 2^32 without saturation.
- Reset mid-transaction: the memory shares rst, so a pending AR/R is abandoned. The IFU restarts in REQ at RESET_PC.

Optional Feature:
YSYX_25040101_IFU_PERF_EN
- Defined:
  - fetch_cnt_o increments on each R beat accepted with OKAY.
  - stall_cnt_o increments on every cycle the state is REQ or WAIT.
- Undefined: both ports remain in the port list but are tied to 32'h0, and no counter flops are synthesized.

Decomposition:
- Package ysyx_25040101_pkg:
  - IFU state enum (REQ/WAIT/VALID/HALT, 2-bit)
  - RRESP_OKAY constant
  - default RESET_PC constant
- Sub-module ysyx_25040101_ifu_perf holds the two counters and is instantiated only under YSYX_25040101_IFU_PERF_EN.
- The FSM and datapath stay in the top module.

Test Plan:
- Reset release, memory arready_i=1, rvalid_i=1 next cycle, rdata_i=32'h00000413, inst_ready_i=1, next_pc_i=32'h80000004:
  - cycle 0: arvalid_o=1, araddr_o=32'h80000000
  - cycle 2: inst_valid_o=1, inst_o=32'h00000413
  - cycle 3: araddr_o=32'h80000004
- arready_i held low 4 cycles, then rvalid_i delayed 3 cycles -> araddr_o stable throughout; inst_valid_o rises 1 cycle after the R beat; stall_cnt_o=9 (PERF_EN).
- inst_ready_i low 5 cycles while in VALID -> inst_o/pc_o unchanged, arvalid_o=0; next_pc_i is taken only on the ready cycle.
- rresp_i=2'b10 on the first beat -> fetch_err_o=1 next cycle, arvalid_o/inst_valid_o stay 0 for 20 cycles; a rst pulse clears fetch_err_o and refetches 32'h80000000.
- Handshake with next_pc_i=32'h80000006 -> fetch_err_o=1, no AR issued.
- rst asserted mid-WAIT -> outputs reach reset values immediately (asynchronous); after release, araddr_o=32'h80000000 and fetch_cnt_o=0.
